// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with runtime modulus, parallel load, wrap/saturate mode,
// enable-gated cascade carry, registered wrap pulse and sticky saturation flag.
module mod_updown_counter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_COUNT = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_up_dn,
   input  logic             i_sat_mode,
   input  logic [WIDTH-1:0] i_mod_val,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc,
   output logic             o_carry,
   output logic             o_wrap_pulse,
   output logic             o_sat_flag
);

   // One extra bit so a modulus of 2^WIDTH is representable.
   localparam logic [WIDTH:0] MaxCnt = (WIDTH+1)'(MAX_COUNT);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_d;
   logic             r_wrap;
   logic             w_wrap_d;
   logic             r_sat;
   logic             w_sat_d;

   logic [WIDTH:0]   w_mod;
   logic [WIDTH:0]   w_last;
   logic [WIDTH:0]   w_cnt_ext;
   logic             w_oor;
   logic             w_at_top;
   logic             w_at_bot;
   logic             w_tc;

   always_comb begin
      w_mod     = (i_mod_val == '0) ? MaxCnt : {1'b0, i_mod_val};
      w_last    = w_mod - (WIDTH+1)'(1);
      w_cnt_ext = {1'b0, r_count};
      w_oor     = (w_cnt_ext >= w_mod);
      w_at_top  = (w_cnt_ext == w_last);
      w_at_bot  = (r_count == '0);
      w_tc      = ~w_oor & (i_up_dn ? w_at_top : w_at_bot);
   end

   always_comb begin
      w_count_d = r_count;
      w_wrap_d  = 1'b0;
      w_sat_d   = r_sat;
      if (i_clr) begin
         w_count_d = '0;
         w_sat_d   = 1'b0;
      end else if (i_load) begin
         w_count_d = ({1'b0, i_load_val} >= w_mod) ? w_last[WIDTH-1:0] : i_load_val;
      end else if (i_en) begin
         if (w_oor) begin
            // Modulus shrank below the count: re-enter range at the terminal, as a wrap.
            w_count_d = i_up_dn ? '0 : w_last[WIDTH-1:0];
            w_wrap_d  = 1'b1;
         end else if (w_tc) begin
            if (i_sat_mode) begin
               w_sat_d = 1'b1;
            end else begin
               w_count_d = i_up_dn ? '0 : w_last[WIDTH-1:0];
               w_wrap_d  = 1'b1;
            end
         end else if (i_up_dn) begin
            w_count_d = r_count + WIDTH'(1);
         end else begin
            w_count_d = r_count - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         r_count <= w_count_d;
         r_wrap  <= w_wrap_d;
         r_sat   <= w_sat_d;
      end
   end

   assign o_count      = r_count;
   assign o_tc         = w_tc;
   assign o_carry      = w_tc & i_en & ~i_sat_mode & ~i_clr & ~i_load & ~i_rst;
   assign o_wrap_pulse = r_wrap;
   assign o_sat_flag   = r_sat;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: a behavioural model pushes expected state per
// cycle, popped and compared after the edge; plus a two-stage decimal cascade.
module tb_mod_updown_counter;

   typedef struct {
      int cnt;
      bit wrap;
      bit sat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0, en = 1'b0, clr = 1'b0, load = 1'b0, up_dn = 1'b1, sat_mode = 1'b0;
   logic [7:0] load_val = '0, mod_val = '0;
   logic [7:0] count;
   logic       tc, carry, wrap_pulse, sat_flag;

   logic       c_rst = 1'b0;
   logic [3:0] c1_count, c2_count;
   logic       c1_tc, c1_carry, c1_wrap, c1_sat;
   logic       c2_tc, c2_carry, c2_wrap, c2_sat;

   int   n_total = 0;
   int   n_bad   = 0;
   exp_t sb_q[$];
   int   m_cnt   = 0;
   bit   m_wrap  = 0, m_sat = 0, m_valid = 0;

   always #5 clk = ~clk;

   mod_updown_counter #(.WIDTH(8), .MAX_COUNT(16)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_load(load), .i_load_val(load_val),
      .i_up_dn(up_dn), .i_sat_mode(sat_mode), .i_mod_val(mod_val), .o_count(count), .o_tc(tc),
      .o_carry(carry), .o_wrap_pulse(wrap_pulse), .o_sat_flag(sat_flag)
   );

   mod_updown_counter #(.WIDTH(4), .MAX_COUNT(10)) u_c1 (
      .i_clk(clk), .i_rst(c_rst), .i_en(1'b1), .i_clr(1'b0), .i_load(1'b0), .i_load_val(4'd0),
      .i_up_dn(1'b1), .i_sat_mode(1'b0), .i_mod_val(4'd0), .o_count(c1_count), .o_tc(c1_tc),
      .o_carry(c1_carry), .o_wrap_pulse(c1_wrap), .o_sat_flag(c1_sat)
   );

   mod_updown_counter #(.WIDTH(4), .MAX_COUNT(10)) u_c2 (
      .i_clk(clk), .i_rst(c_rst), .i_en(c1_carry), .i_clr(1'b0), .i_load(1'b0),
      .i_load_val(4'd0), .i_up_dn(1'b1), .i_sat_mode(1'b0), .i_mod_val(4'd0),
      .o_count(c2_count), .o_tc(c2_tc), .o_carry(c2_carry), .o_wrap_pulse(c2_wrap),
      .o_sat_flag(c2_sat)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive, check combinational outputs, predict, clock, compare.
   task automatic cyc(input bit i_r, input bit i_c, input bit i_l, input bit i_e,
                      input int lv, input bit up, input bit sm, input int mv);
      int   mm, last;
      bit   exp_tc, at_term;
      exp_t e;
      rst = i_r; clr = i_c; load = i_l; en = i_e;
      load_val = 8'(lv); up_dn = up; sat_mode = sm; mod_val = 8'(mv);
      #2;
      mm     = (mv == 0) ? 16 : mv;
      last   = mm - 1;
      at_term = up ? (m_cnt == last) : (m_cnt == 0);
      exp_tc = (m_cnt < mm) && at_term;
      if (m_valid) check("tc", int'(tc), int'(exp_tc));
      check("carry", int'(carry), int'(m_valid && exp_tc && i_e && !sm && !i_c && !i_l && !i_r));
      if (i_r || i_c) begin
         m_cnt = 0; m_wrap = 0; m_sat = 0;
      end else if (i_l) begin
         m_cnt = (lv >= mm) ? last : lv; m_wrap = 0;
      end else if (i_e) begin
         if (m_cnt >= mm) begin
            m_cnt = up ? 0 : last; m_wrap = 1;
         end else if (at_term && sm) begin
            m_sat = 1; m_wrap = 0;
         end else if (at_term) begin
            m_cnt = up ? 0 : last; m_wrap = 1;
         end else begin
            m_cnt = up ? m_cnt + 1 : m_cnt - 1; m_wrap = 0;
         end
      end else begin
         m_wrap = 0;
      end
      m_valid = 1;
      e.cnt = m_cnt; e.wrap = m_wrap; e.sat = m_sat;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         check("count", int'(count), e.cnt);
         check("wrap_pulse", int'(wrap_pulse), int'(e.wrap));
         check("sat_flag", int'(sat_flag), int'(e.sat));
      end
   endtask

   initial begin
      int k;
      @(posedge clk);
      #1;
      // Reset
      cyc(1, 0, 0, 0, 0, 1, 0, 0);
      // Up wrap, default modulus 16
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0, 1, 0, 0);
      // Down wrap with runtime modulus 5
      cyc(0, 0, 1, 0, 2, 0, 0, 5);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0, 5);
      // Saturate at 9 with modulus 10, flag sticky until clr
      cyc(0, 0, 1, 0, 8, 1, 1, 10);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 1, 1, 10);
      cyc(0, 0, 0, 0, 0, 1, 1, 10);
      cyc(0, 1, 0, 1, 0, 1, 1, 10);
      // Saturate at 0 going down
      for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0, 0, 1, 10);
      // Load clamp and priority
      cyc(0, 0, 1, 1, 200, 1, 0, 6);
      cyc(0, 1, 1, 1, 200, 1, 0, 6);
      cyc(0, 0, 1, 1, 200, 1, 0, 6);
      cyc(1, 1, 1, 1, 3, 1, 0, 6);
      // Out of range after modulus shrink
      cyc(0, 0, 1, 0, 12, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 8);
      cyc(0, 0, 0, 1, 0, 1, 0, 8);
      cyc(0, 0, 1, 0, 12, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 8);
      cyc(0, 0, 0, 1, 0, 0, 0, 8);
      // Modulus 1: every step wraps or saturates
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 1, 0, 1);
      for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0, 0, 1, 1);
      // Modulus 255 and 0 boundaries of 8-bit range
      cyc(0, 0, 1, 0, 254, 1, 0, 255);
      for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0, 1, 0, 255);
      // Random mix
      for (int i = 0; i < 300; i++)
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
             int'($urandom_range(0, 255)), 1'($urandom), ($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 20)));

      // Two-stage decimal cascade
      c_rst = 1'b1;
      @(posedge clk);
      #1;
      c_rst = 1'b0;
      for (k = 0; k <= 100; k++) begin
         check("cascade_value", int'(c2_count) * 10 + int'(c1_count), k % 100);
         check("cascade_c1_carry", int'(c1_carry), int'((k % 10) == 9));
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
